// File: rtl/baud_tick_gen_if.sv
// Signal bundle between the baud tick generator and its UART clients:
// count control, divisor reload handshake, and the generated ticks.
interface baud_tick_gen_if #(
  parameter int DIV_W      = 16,
  parameter int FRAC_BITS  = 8,
  parameter int OVERSAMPLE = 16
);
  logic                                en;
  logic                                resync;
  logic                                cfg_valid;
  logic [DIV_W+FRAC_BITS-1:0]          cfg_div;
  logic                                cfg_ready;
  logic                                tick_os;
  logic                                tick_mid;
  logic                                tick_bit;
  logic [$clog2(OVERSAMPLE)-1:0]       os_idx;
  logic [DIV_W+FRAC_BITS-1:0]          div_active;

  modport master (
    output en, resync, cfg_valid, cfg_div,
    input  cfg_ready, tick_os, tick_mid, tick_bit, os_idx, div_active
  );

  modport slave (
    input  en, resync, cfg_valid, cfg_div,
    output cfg_ready, tick_os, tick_mid, tick_bit, os_idx, div_active
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional-accumulator baud tick generator: oversample, mid-bit and bit
// ticks from one clock, with a handshaked divisor reload and phase resync.
module baud_tick_gen #(
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter logic [DIV_W+FRAC_BITS-1:0] DEFAULT_DIV = (DIV_W+FRAC_BITS)'(
    ((64'(CLK_RATE) << (FRAC_BITS + 1)) + 64'(BAUD_RATE) * 64'(OVERSAMPLE))
    / (64'(BAUD_RATE) * 64'(OVERSAMPLE) * 64'd2))
) (
  input  logic            CLK_100MHZ,
  input  logic            reset,
  baud_tick_gen_if.slave  bus
);

  localparam int CFG_W = DIV_W + FRAC_BITS;
  localparam int ACC_W = CFG_W + 1;
  localparam int IDX_W = $clog2(OVERSAMPLE);

  localparam logic [ACC_W-1:0] ONE     = ACC_W'(1 << FRAC_BITS);
  localparam logic [CFG_W-1:0] MIN_DIV = CFG_W'(2 << FRAC_BITS);
  localparam logic [IDX_W-1:0] MID_IDX = IDX_W'(OVERSAMPLE / 2);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]       state;
  logic             ready_q;
  logic [CFG_W-1:0] div_q;
  logic [CFG_W-1:0] pend_div;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx_q;
  logic             tick_os_q;
  logic             tick_mid_q;
  logic             tick_bit_q;

  logic [CFG_W-1:0] cfg_clamped;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_next;
  logic [IDX_W-1:0] idx_next;
  logic             hit;
  logic             tick_now;
  logic             take_cfg;
  logic             apply_now;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    cfg_clamped = bus.cfg_div;
    take_cfg    = bus.cfg_valid && ready_q;
    sum         = acc + ONE;
    hit         = (sum >= {1'b0, div_q});
    tick_now    = bus.en && !bus.resync && hit;
    idx_next    = idx_q + IDX_W'(1);
    apply_now   = (state == ST_PEND) && (bus.resync || !bus.en || tick_now);
    acc_next    = acc;

    if (bus.cfg_div < MIN_DIV) cfg_clamped = MIN_DIV;

    if (bus.resync) begin
      acc_next = '0;
    end else if (bus.en) begin
      acc_next = hit ? (sum - {1'b0, div_q}) : sum;
    end else if (apply_now && (acc >= {1'b0, pend_div})) begin
      // A smaller divisor loaded while idle must not leave acc above it,
      // otherwise ticks would fire back-to-back until the excess drained.
      acc_next = {1'b0, pend_div} - ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      acc        <= '0;
      idx_q      <= '0;
      tick_os_q  <= 1'b0;
      tick_mid_q <= 1'b0;
      tick_bit_q <= 1'b0;
      div_q      <= DEFAULT_DIV;
      state      <= ST_IDLE;
      ready_q    <= 1'b1;
      // NOTE: the pending divisor is cleared too, so a reset can never let
      // a stale value slip into div_active later.
      pend_div   <= '0;
    end else begin
      acc        <= acc_next;
      tick_os_q  <= tick_now;
      tick_bit_q <= tick_now && (idx_next == '0);
      tick_mid_q <= tick_now && (idx_next == MID_IDX);

      if (bus.resync)    idx_q <= '0;
      else if (tick_now) idx_q <= idx_next;

      // A resync coinciding with a handshake takes the new value directly.
      if (bus.resync && take_cfg) begin
        div_q <= cfg_clamped;
      end else if (apply_now) begin
        div_q   <= pend_div;
        state   <= ST_IDLE;
        ready_q <= 1'b1;
      end else if (take_cfg) begin
        pend_div <= cfg_clamped;
        state    <= ST_PEND;
        ready_q  <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready  = ready_q;
  assign bus.tick_os    = tick_os_q;
  assign bus.tick_mid   = tick_mid_q;
  assign bus.tick_bit   = tick_bit_q;
  assign bus.os_idx     = idx_q;
  assign bus.div_active = div_q;

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised, runtime-programmable baud tick generator for the debug-unit UART. A fixed-point fractional accumulator produces an oversampling tick, a bit tick and a mid-bit sample tick. The divisor can be reloaded through a valid/ready handshake. A resync input realigns the phase to a received start-bit edge. It feeds both the UART RX (oversample and mid-bit ticks) and the UART TX (bit tick) from one clock domain.

## Interface
- CLK_RATE, 100000000: input clock frequency in Hz; used only for the reset divisor.
- BAUD_RATE, 9600: reset baud rate in bit/s.
- OVERSAMPLE, 16: oversample ticks per bit.
  - Must be a power of two and at least 4.
- FRAC_BITS, 8: fractional bits of the divisor.
- DIV_W, 16: integer bits of the divisor.
- DEFAULT_DIV, round(CLK_RATE*2^FRAC_BITS/(BAUD_RATE*OVERSAMPLE)): reset divisor; 166667 (651.04 cycles) at the defaults.
- CLK_100MHZ, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: count enable. While low, the accumulator holds and no ticks are generated.
- resync, input, 1: one-cycle phase realign request.
- cfg_valid, input, 1: a new divisor is offered.
- cfg_div, input, DIV_W+FRAC_BITS: new divisor in unsigned fixed-point Q(DIV_W).(FRAC_BITS).
- cfg_ready, output, 1: the block can accept a divisor.
- tick_os, output, 1: one-cycle oversample tick.
- tick_mid, output, 1: one-cycle pulse on the tick_os where os_idx becomes OVERSAMPLE/2.
- tick_bit, output, 1: one-cycle pulse on the tick_os where os_idx wraps to 0.
- os_idx, output, $clog2(OVERSAMPLE): current oversample index within the bit.
- div_active, output, DIV_W+FRAC_BITS: divisor currently in use.

## Operation
- Definitions:
  - ONE = 2^FRAC_BITS.
  - acc is an unsigned register of width DIV_W+FRAC_BITS+1.
- Accumulator, evaluated each cycle when en=1 and resync=0:
  - sum = acc + ONE.
  - If sum >= div_active: acc <= sum - div_active, the fractional remainder is kept, and a tick_os is generated.
  - Otherwise: acc <= sum.
- Average tick_os period is div_active/ONE cycles.
  - Integer divisors give a constant period.
  - Fractional divisors give periods of floor or ceil, with no long-term drift.
- Divisor clamping: any cfg_div below 2*ONE is clamped to 2*ONE, so ticks are never back-to-back.
- os_idx:
  - Increments modulo OVERSAMPLE on every tick_os.
  - tick_bit is asserted with the tick_os that takes os_idx from OVERSAMPLE-1 to 0.
  - tick_mid is asserted with the tick_os that takes os_idx to OVERSAMPLE/2.
- Config handshake:
  - A transfer occurs when cfg_valid and cfg_ready are both high on a rising edge. The value (clamped) is captured into a pending register and cfg_ready drops.
  - The pending value becomes div_active at the first of these events:
    - the next tick_os, applied after that tick's accumulator update;
    - any cycle with en=0;
    - a resync.
  - cfg_ready rises in the cycle after the pending value is applied.
- Resync:
  - Sets acc to 0 and os_idx to 0.
  - Suppresses any tick that would have fired in that cycle.
  - Applies any pending divisor.
  - Works regardless of en.
- FSM with two states:
  - IDLE: cfg_ready=1, nothing pending. A handshake moves it to PEND.
  - PEND: cfg_ready=0. Applying the pending divisor returns it to IDLE.

## Timing
- Reset values:
  - acc=0, os_idx=0.
  - tick_os=0, tick_mid=0, tick_bit=0.
  - div_active=DEFAULT_DIV.
  - cfg_ready=1, state IDLE, pending register cleared.
- All outputs are registered.
- A tick computed on edge k is high during the cycle after edge k, for exactly one cycle.
- With integer divisor N and en held high from reset release:
  - the first tick_os appears after N enabled edges;
  - subsequent ticks follow every N cycles.
- After a resync on edge r, the first tick_os follows N enabled edges after r.
- en low for M cycles stretches the current period by exactly M cycles.
- Simultaneous events:
  - resync with a would-be tick: no tick, and os_idx=0.
  - resync with a cfg handshake: the new value is captured and applied on the same edge, and cfg_ready stays 1.
  - A tick with a pending apply: that tick uses the old divisor, and the next period uses the new one.
- Reset mid-operation restores all reset values on the next edge and discards any pending divisor.

## Test plan
- Default divisor after reset, en=1:
  - tick_os intervals are 651 or 652 cycles;
  - 256 ticks span 166667 ±1 cycles;
  - tick_bit occurs every 16th tick_os, and tick_mid coincides with os_idx=8.
- Integer divisor:
  - Load cfg_div=10*256 (0x0A00), then hold en=1.
  - Required: ticks exactly every 10 cycles, and tick_bit every 160 cycles.
- Fractional divisor:
  - Load cfg_div=0x0A80 (10.5).
  - Required: intervals alternate 10/11, and 16 tick_os span 168 cycles.
- Clamp and handshake:
  - Load cfg_div=0x0001.
  - Required: div_active=0x0200, and ticks occur every 2 cycles.
  - While pending, cfg_ready=0 and a second cfg_valid is ignored.
  - Required: cfg_ready returns 1 the cycle after the apply.
- Enable and resync:
  - With div=0x0A00, drop en for 5 cycles mid-period. Required: that interval becomes 15 cycles.
  - Pulse resync on a would-be tick cycle. Required: no tick, os_idx=0, and the next tick 10 cycles later.
- Reset mid-operation:
  - With a divisor pending at os_idx=7, assert reset for 1 cycle.
  - Required: all outputs return to their reset values, div_active=166667, and the pending value is never applied.
